alu_div_iter: RTL

Parametrised radix-2 restoring iterative divider for the EX-stage ALU, successor to the fixed 64-bit divider top. Supports signed/unsigned and word (32-bit) operations at any XLEN, with RISC-V divide-by-zero and overflow semantics. Word results are sign-extended. Special cases complete early, and a flush input aborts an operation in flight. It has an explicit start/idle/done handshake toward the pipeline controller.

---
 rtl/alu_div_if.sv | 29 ++
 rtl/alu_div_iter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_div_if.sv
// Request/result bundle between the EX-stage pipeline controller and the
// iterative divider.
interface alu_div_if #(
   parameter int XLEN = 64
);
   // A request is taken on a rising edge when div_valid_i=1, div_idle_o=1 and
   // flush_i=0; div_ready_o pulses high for one cycle when div_out_o/rem_out_o
   // carry a new result, and those values hold until the next result.
   logic            flush_i;
   logic            div_valid_i;
   logic            signed_valid_i;
   logic            div32_valid_i;
   logic [XLEN-1:0] sr1_data_i;
   logic [XLEN-1:0] sr2_data_i;
   logic            div_idle_o;
   logic            div_ready_o;
   logic [XLEN-1:0] div_out_o;
   logic [XLEN-1:0] rem_out_o;

   modport master (
      output flush_i, div_valid_i, signed_valid_i, div32_valid_i, sr1_data_i, sr2_data_i,
      input  div_idle_o, div_ready_o, div_out_o, rem_out_o
   );

   modport slave (
      input  flush_i, div_valid_i, signed_valid_i, div32_valid_i, sr1_data_i, sr2_data_i,
      output div_idle_o, div_ready_o, div_out_o, rem_out_o
   );
endinterface

// File: rtl/alu_div_iter.sv
// Radix-2 restoring iterative divider with RISC-V signed/unsigned/word
// semantics, early completion of special cases and flush abort.
module alu_div_iter #(
   parameter int XLEN     = 64,
   parameter bit HAS_WORD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   alu_div_if.slave   bus,
   output logic [1:0] dbg_state
);
   localparam int CW = $clog2(XLEN);
   localparam logic [31:0] W_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t          state;
   logic [XLEN-1:0] dvd, dsr, quo, rem;
   logic [CW-1:0]   cnt;
   logic            word_op, neg_q, neg_r;
   logic            ready_q;
   logic [XLEN-1:0] q_q, r_q;

   logic            idle, word_req, accept, sign1, sign2, is_zero, is_ovf;
   logic [XLEN-1:0] op1, op2, mag1, mag2, min_val, sp_q, sp_r, fix_q, fix_r;
   logic [XLEN:0]   shifted, diff;

   // W-family results are always the low word sign-extended, signed or not.
   function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic w);
      logic [XLEN-1:0] y;
      if (w) y = XLEN'($signed(x[31:0]));
      else   y = x;
      return y;
   endfunction

   always_comb begin
      idle     = (state == IDLE) || (state == DONE);
      word_req = HAS_WORD && bus.div32_valid_i;
      accept   = bus.div_valid_i && idle && !bus.flush_i;
      op1      = bus.sr1_data_i;
      op2      = bus.sr2_data_i;
      min_val  = {1'b1, {(XLEN-1){1'b0}}};
      if (word_req) begin
         min_val = XLEN'($signed(W_MIN));
         if (bus.signed_valid_i) begin
            op1 = XLEN'($signed(bus.sr1_data_i[31:0]));
            op2 = XLEN'($signed(bus.sr2_data_i[31:0]));
         end else begin
            op1 = XLEN'(bus.sr1_data_i[31:0]);
            op2 = XLEN'(bus.sr2_data_i[31:0]);
         end
      end
      sign1   = bus.signed_valid_i && op1[XLEN-1];
      sign2   = bus.signed_valid_i && op2[XLEN-1];
      mag1    = sign1 ? -op1 : op1;
      mag2    = sign2 ? -op2 : op2;
      is_zero = (op2 == '0);
      is_ovf  = bus.signed_valid_i && (op1 == min_val) && (op2 == '1);
      sp_q    = wfix(is_zero ? '1 : op1, word_req);
      sp_r    = wfix(is_zero ? op1 : '0, word_req);
      // One restoring step: bring in the next dividend bit and try to subtract.
      shifted = {rem, dvd[XLEN-1]};
      diff    = shifted - {1'b0, dsr};
      fix_q   = wfix(neg_q ? -quo : quo, word_op);
      fix_r   = wfix(neg_r ? -rem : rem, word_op);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         dvd     <= '0;
         dsr     <= '0;
         quo     <= '0;
         rem     <= '0;
         cnt     <= '0;
         word_op <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         ready_q <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               ready_q <= 1'b0;
               state   <= IDLE;
               if (accept) begin
                  // Word dividends are left-aligned so the MSB always feeds the step.
                  dvd     <= word_req ? (mag1 << (XLEN - 32)) : mag1;
                  dsr     <= mag2;
                  quo     <= '0;
                  rem     <= '0;
                  cnt     <= word_req ? CW'(31) : CW'(XLEN - 1);
                  word_op <= word_req;
                  neg_q   <= sign1 ^ sign2;
                  neg_r   <= sign1;
                  if (is_zero || is_ovf) begin
                     state   <= DONE;
                     ready_q <= 1'b1;
                     q_q     <= sp_q;
                     r_q     <= sp_r;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (bus.flush_i) begin
                  state <= IDLE;
               end else begin
                  dvd <= dvd << 1;
                  quo <= {quo[XLEN-2:0], ~diff[XLEN]};
                  rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                  if (cnt == '0) state <= FIX;
                  else           cnt   <= cnt - 1'b1;
               end
            end
            FIX: begin
               if (bus.flush_i) begin
                  state <= IDLE;
               end else begin
                  state   <= DONE;
                  ready_q <= 1'b1;
                  q_q     <= fix_q;
                  r_q     <= fix_r;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.div_idle_o  = idle;
   assign bus.div_ready_o = ready_q;
   assign bus.div_out_o   = q_q;
   assign bus.rem_out_o   = r_q;
   assign dbg_state       = state;
endmodule
